uart_rx: RTL and testbench

//  8N1 serial receiver; consumer of the transmitter's serial line (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit).

---
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit oversampled sampling and framing-error detection
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects the sense).
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_srx,
  output logic       o_Rx_valid,
  output logic [7:0] o_Rx_data,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t          state;
  logic            sync1;
  logic            line;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
`ifdef UART_RX_PARITY_EN
  logic            parity_bit;
  logic            parity_err;
`endif

  // Both flops reset high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= i_srx;
      line  <= sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      o_Rx_valid  <= 1'b0;
      o_Rx_data   <= 8'h00;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit  <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      o_Rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (i_tick) begin
        case (state)
          IDLE: begin
            if (!line) begin
              tick_cnt <= '0;
              state    <= START;
              o_busy   <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              if (line) begin
                state  <= IDLE;
                o_busy <= 1'b0;
              end else begin
                tick_cnt <= '0;
                bit_cnt  <= 3'd0;
                state    <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {line, shreg[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt   <= '0;
              parity_bit <= line;
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
`endif
          // Deciding at mid-stop leaves half a bit to catch an immediately following start bit.
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (line) begin
                o_Rx_data  <= shreg;
                o_Rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= ((^{shreg, parity_bit}) != PARITY_ODD);
`endif
                state      <= IDLE;
                o_busy     <= 1'b0;
              end else begin
                o_frame_err <= 1'b1;
                state       <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          BREAK: begin
            if (line) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err;
`else
  assign o_parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx (OVERSAMPLE=16, tick every 4 clocks)
module tb_uart_rx;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       srx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_perr  = 0;
  int         n_bad   = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [7:0] log_mem [0:255];

  uart_rx #(.OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_tick       (tick),
    .i_srx        (srx),
    .o_Rx_valid   (rx_valid),
    .o_Rx_data    (rx_data),
    .o_frame_err  (frame_err),
    .o_parity_err (parity_err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Pulse monitor: logs bytes and counts protocol violations on pulse outputs.
  always @(negedge clk) begin
    prev_valid <= rx_valid;
    prev_ferr  <= frame_err;
    if (rx_valid) begin
      log_mem[n_valid[7:0]] <= rx_data;
      n_valid <= n_valid + 1;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if ((rx_valid && frame_err) || (parity_err && !rx_valid) ||
        (rx_valid && prev_valid) || (frame_err && prev_ferr))
      n_bad <= n_bad + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic send_bit(input logic b);
    srx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic idle_after);
    send_body(d);
    send_bit(stop_bit);
    if (idle_after) begin
      srx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int bv;
    int bf;
    int bp;

    rst = 1'b1;
    srx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_perr", {31'd0, parity_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    vecs[0] = '{8'h3C, 1'b0, 0, 1, 8'h00};
    vecs[1] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'hA5, 1'b1, 1, 0, 8'hA5};

    for (int i = 0; i < 5; i++) begin
      bv = n_valid;
      bf = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop, 1'b1);
      check($sformatf("vec%0d_valid_cnt", i), n_valid - bv, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr_cnt", i), n_ferr - bf, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    // False start: 4 ticks low then high.
    bv = n_valid;
    bf = n_ferr;
    srx = 1'b0;
    repeat (16) @(negedge clk);
    check("fs_busy_high", {31'd0, busy}, 32'd1);
    srx = 1'b1;
    repeat (40) @(negedge clk);
    check("fs_busy_low", {31'd0, busy}, 32'd0);
    repeat (BIT) @(negedge clk);
    check("fs_no_valid", n_valid - bv, 0);
    check("fs_no_ferr", n_ferr - bf, 0);

    // Bad stop followed by a 20 bit-time break.
    bv = n_valid;
    bf = n_ferr;
    send_body(8'h3C);
    srx = 1'b0;
    repeat (21 * BIT) @(negedge clk);
    check("brk_busy_held", {31'd0, busy}, 32'd1);
    srx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("brk_ferr_once", n_ferr - bf, 1);
    check("brk_no_valid", n_valid - bv, 0);
    check("brk_data_kept", {24'd0, rx_data}, 32'hA5);
    bv = n_valid;
    send_frame(8'h81, 1'b1, 1'b1);
    check("post_brk_valid", n_valid - bv, 1);
    check("post_brk_data", {24'd0, rx_data}, 32'h81);

    // Back-to-back frames with no idle gap.
    bv = n_valid;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    check("b2b_count", n_valid - bv, 2);
    check("b2b_first", {24'd0, log_mem[bv[7:0]]}, 32'h00);
    check("b2b_second", {24'd0, log_mem[bv[7:0] + 8'd1]}, 32'hFF);

    // Reset in the middle of data bit 3 of 0x55.
    bv = n_valid;
    bf = n_ferr;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    srx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    srx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b1);
    check("rst_mid_valid_cnt", n_valid - bv, 1);
    check("rst_mid_data", {24'd0, log_mem[bv[7:0]]}, 32'h12);
    check("rst_mid_no_ferr", n_ferr - bf, 0);

`ifdef UART_RX_PARITY_EN
    bv = n_valid;
    bp = n_perr;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b0);
    send_bit(1'b1);
    srx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("par_valid", n_valid - bv, 1);
    check("par_err", n_perr - bp, 1);
    check("par_data", {24'd0, rx_data}, 32'h07);
`else
    bp = n_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    check("noparity_perr", n_perr - bp, 0);
    check("noparity_data", {24'd0, rx_data}, 32'h07);
`endif

    check("pulse_protocol", n_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
